// File: rtl/free_list_pkg.sv
// Shared system definitions for the rename free list: PR/ROB widths, slot
// count and the 3-slot popcount used by dispatch and retire.
package free_list_pkg;
    localparam int PR        = 6;
    localparam int ROB       = 5;
    localparam int SLOTS     = 3;
    localparam int FL_SIZE   = 2 ** ROB;
    localparam int ARCH_REGS = 32;

    function automatic logic [1:0] popcount3(input logic [SLOTS-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction
endpackage

// File: rtl/free_list.sv
// Circular free list of physical registers: 3-wide pop at dispatch, 3-wide
// push at retire, head rollback on branch recovery.
module free_list
    import free_list_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [SLOTS-1:0]         DispatchEN,
    output logic [SLOTS-1:0][PR-1:0] FreeReg,
    output logic [1:0]               fl_avail,
    input  logic [SLOTS-1:0]         Retire_EN,
    input  logic [SLOTS-1:0][PR-1:0] Tolds_in,
    input  logic                     BPRecoverEN,
    input  logic [ROB-1:0]           BPRecoverHead,
    output logic [ROB-1:0]           FreelistHead,
    output logic [ROB-1:0]           fl_distance
);
    logic [PR-1:0]  r_entries [FL_SIZE];
    logic [ROB-1:0] r_head;
    logic [ROB-1:0] r_tail;
    logic [ROB:0]   r_count;

    logic [SLOTS-1:0][1:0]     w_pop_off;
    logic [SLOTS-1:0][1:0]     w_push_off;
    logic [SLOTS-1:0][ROB-1:0] w_rd_idx;
    logic [SLOTS-1:0][ROB-1:0] w_wr_idx;
    logic [1:0]                w_npop;
    logic [1:0]                w_npush;
    logic [ROB:0]              w_free;

    // Slot 2 is oldest, so it takes offset 0 and younger slots stack behind it.
    assign w_pop_off[2]  = 2'd0;
    assign w_pop_off[1]  = {1'b0, DispatchEN[2]};
    assign w_pop_off[0]  = {1'b0, DispatchEN[2]} + {1'b0, DispatchEN[1]};
    assign w_push_off[2] = 2'd0;
    assign w_push_off[1] = {1'b0, Retire_EN[2]};
    assign w_push_off[0] = {1'b0, Retire_EN[2]} + {1'b0, Retire_EN[1]};

    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        assign w_rd_idx[k] = r_head + ROB'(w_pop_off[k]);
        assign w_wr_idx[k] = r_tail + ROB'(w_push_off[k]);
        assign FreeReg[k]  = DispatchEN[k] ? r_entries[w_rd_idx[k]] : '0;
    end

    assign w_npop   = popcount3(DispatchEN);
    assign w_npush  = popcount3(Retire_EN);
    assign w_free   = (ROB+1)'(FL_SIZE) - r_count;
    assign fl_avail = (w_free >= (ROB+1)'(3)) ? 2'd3 : w_free[1:0];

    assign FreelistHead = r_head;
    assign fl_distance  = r_count[ROB-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail <= r_tail + ROB'(w_npush);
            if (BPRecoverEN) begin
                // Everything younger than the retiring branch is squashed.
                r_head  <= BPRecoverHead;
                r_count <= '0;
            end else begin
                r_head  <= r_head + ROB'(w_npop);
                r_count <= r_count + (ROB+1)'(w_npop) - (ROB+1)'(w_npush);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++)
                r_entries[i] <= PR'(ARCH_REGS + i);
        end else begin
            for (int k = 0; k < SLOTS; k++)
                if (Retire_EN[k])
                    r_entries[w_wr_idx[k]] <= Tolds_in[k];
        end
    end
endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset, compaction, fill/wrap, recovery,
// simultaneous push/pop and reset priority.
module tb_free_list;
    import free_list_pkg::*;

    logic                     clock;
    logic                     reset;
    logic [SLOTS-1:0]         DispatchEN;
    logic [SLOTS-1:0][PR-1:0] FreeReg;
    logic [1:0]               fl_avail;
    logic [SLOTS-1:0]         Retire_EN;
    logic [SLOTS-1:0][PR-1:0] Tolds_in;
    logic                     BPRecoverEN;
    logic [ROB-1:0]           BPRecoverHead;
    logic [ROB-1:0]           FreelistHead;
    logic [ROB-1:0]           fl_distance;

    int tests = 0;
    int fails = 0;
    int m_cnt = 0;

    free_list dut (
        .clock(clock), .reset(reset), .DispatchEN(DispatchEN), .FreeReg(FreeReg),
        .fl_avail(fl_avail), .Retire_EN(Retire_EN), .Tolds_in(Tolds_in),
        .BPRecoverEN(BPRecoverEN), .BPRecoverHead(BPRecoverHead),
        .FreelistHead(FreelistHead), .fl_distance(fl_distance)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Protocol monitor with its own occupancy model.
    initial begin
        forever begin
            @(posedge clock);
            if (reset === 1'b1) begin
                m_cnt = 0;
            end else begin
                if (!BPRecoverEN && int'(popcount3(DispatchEN)) > ((32 - m_cnt) < 3 ? 32 - m_cnt : 3)) begin
                    $display("FAIL proto_overpop: requested=%0d avail=%0d", popcount3(DispatchEN), 32 - m_cnt);
                    fails++;
                end
                if (int'(popcount3(Retire_EN)) > m_cnt) begin
                    $display("FAIL proto_overpush: pushed=%0d count=%0d", popcount3(Retire_EN), m_cnt);
                    fails++;
                end
                for (int k = 0; k < SLOTS; k++)
                    if (Retire_EN[k] && Tolds_in[k] == '0) begin
                        $display("FAIL proto_pr0: slot=%0d pushes PR0", k);
                        fails++;
                    end
                if (BPRecoverEN) m_cnt = 0;
                else m_cnt = m_cnt + int'(popcount3(DispatchEN)) - int'(popcount3(Retire_EN));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1, "timeout");
    end

    task automatic idle();
        DispatchEN = '0; Retire_EN = '0; Tolds_in = '0;
        BPRecoverEN = 1'b0; BPRecoverHead = '0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; tick(); reset = 1'b0; #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (FreelistHead !== 5'd0) begin $display("FAIL rst_head: got=%0d exp=0", FreelistHead); fails++; end
        tests++; if (fl_distance !== 5'd0) begin $display("FAIL rst_dist: got=%0d exp=0", fl_distance); fails++; end
        tests++; if (fl_avail !== 2'd3) begin $display("FAIL rst_avail: got=%0d exp=3", fl_avail); fails++; end
        DispatchEN = 3'b111; #1;
        tests++; if (FreeReg !== {6'd32, 6'd33, 6'd34}) begin $display("FAIL alloc3: got=%h exp=%h", FreeReg, {6'd32, 6'd33, 6'd34}); fails++; end
        tick(); idle(); #1;
        tests++; if (FreelistHead !== 5'd3) begin $display("FAIL alloc3_head: got=%0d exp=3", FreelistHead); fails++; end
        tests++; if (fl_distance !== 5'd3) begin $display("FAIL alloc3_dist: got=%0d exp=3", fl_distance); fails++; end
    endtask

    task automatic test_compaction();
        DispatchEN = 3'b101; #1;
        tests++; if (FreeReg !== {6'd35, 6'd0, 6'd36}) begin $display("FAIL compact: got=%h exp=%h", FreeReg, {6'd35, 6'd0, 6'd36}); fails++; end
        tick(); idle(); #1;
        tests++; if (FreelistHead !== 5'd5) begin $display("FAIL compact_head: got=%0d exp=5", FreelistHead); fails++; end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin DispatchEN = 3'b111; tick(); end
        DispatchEN = 3'b110; tick(); idle(); #1;
        tests++; if (fl_avail !== 2'd0) begin $display("FAIL full_avail: got=%0d exp=0", fl_avail); fails++; end
        tests++; if (fl_distance !== 5'd0) begin $display("FAIL full_dist: got=%0d exp=0", fl_distance); fails++; end
        tests++; if (FreelistHead !== 5'd0) begin $display("FAIL full_head: got=%0d exp=0", FreelistHead); fails++; end
        Retire_EN = 3'b111; Tolds_in = {6'd7, 6'd8, 6'd9};
        tick(); idle(); #1;
        tests++; if (fl_avail !== 2'd3) begin $display("FAIL push_avail: got=%0d exp=3", fl_avail); fails++; end
        tests++; if (fl_distance !== 5'd29) begin $display("FAIL push_dist: got=%0d exp=29", fl_distance); fails++; end
        DispatchEN = 3'b111; #1;
        tests++; if (FreeReg !== {6'd7, 6'd8, 6'd9}) begin $display("FAIL push_data: got=%h exp=%h", FreeReg, {6'd7, 6'd8, 6'd9}); fails++; end
        tick(); idle(); #1;
    endtask

    task automatic test_recovery();
        do_reset();
        DispatchEN = 3'b111; tick(); tick(); idle(); #1;
        tests++; if (FreelistHead !== 5'd6 || fl_distance !== 5'd6) begin $display("FAIL pre_rec: head=%0d dist=%0d exp=6/6", FreelistHead, fl_distance); fails++; end
        BPRecoverEN = 1'b1; BPRecoverHead = 5'd1; Retire_EN = 3'b100;
        Tolds_in = {6'd5, 6'd0, 6'd0}; DispatchEN = 3'b111;
        tick(); idle(); #1;
        tests++; if (FreelistHead !== 5'd1) begin $display("FAIL rec_head: got=%0d exp=1", FreelistHead); fails++; end
        tests++; if (fl_distance !== 5'd0 || fl_avail !== 2'd3) begin $display("FAIL rec_count: dist=%0d avail=%0d exp=0/3", fl_distance, fl_avail); fails++; end
        DispatchEN = 3'b100; #1;
        tests++; if (FreeReg !== {6'd33, 6'd0, 6'd0}) begin $display("FAIL rec_alloc: got=%h exp=%h", FreeReg, {6'd33, 6'd0, 6'd0}); fails++; end
        tick(); idle(); #1;
        tests++; if (FreelistHead !== 5'd2) begin $display("FAIL rec_head2: got=%0d exp=2", FreelistHead); fails++; end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin DispatchEN = 3'b111; tick(); end
        DispatchEN = 3'b100; tick(); idle(); #1;
        tests++; if (fl_distance !== 5'd31 || fl_avail !== 2'd1) begin $display("FAIL c31: dist=%0d avail=%0d exp=31/1", fl_distance, fl_avail); fails++; end
        DispatchEN = 3'b100; Retire_EN = 3'b110; Tolds_in = {6'd10, 6'd11, 6'd0}; #1;
        tests++; if (FreeReg !== {6'd63, 6'd0, 6'd0}) begin $display("FAIL sim_alloc: got=%h exp=%h", FreeReg, {6'd63, 6'd0, 6'd0}); fails++; end
        tick(); idle(); #1;
        tests++; if (fl_distance !== 5'd30 || fl_avail !== 2'd2) begin $display("FAIL sim_count: dist=%0d avail=%0d exp=30/2", fl_distance, fl_avail); fails++; end
        tests++; if (FreelistHead !== 5'd0) begin $display("FAIL sim_head: got=%0d exp=0", FreelistHead); fails++; end
        DispatchEN = 3'b110; #1;
        tests++; if (FreeReg !== {6'd10, 6'd11, 6'd0}) begin $display("FAIL sim_push: got=%h exp=%h", FreeReg, {6'd10, 6'd11, 6'd0}); fails++; end
        tick(); idle(); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        DispatchEN = 3'b111; tick(); idle();
        Retire_EN = 3'b100; Tolds_in = {6'd20, 6'd0, 6'd0}; tick(); idle();
        reset = 1'b1; BPRecoverEN = 1'b1; BPRecoverHead = 5'd2;
        Retire_EN = 3'b100; Tolds_in = {6'd21, 6'd0, 6'd0}; DispatchEN = 3'b111;
        tick(); reset = 1'b0; idle(); #1;
        tests++; if (FreelistHead !== 5'd0 || fl_distance !== 5'd0 || fl_avail !== 2'd3) begin
            $display("FAIL rstmid_state: head=%0d dist=%0d avail=%0d exp=0/0/3", FreelistHead, fl_distance, fl_avail); fails++; end
        DispatchEN = 3'b111; #1;
        tests++; if (FreeReg !== {6'd32, 6'd33, 6'd34}) begin $display("FAIL rstmid_entries: got=%h exp=%h", FreeReg, {6'd32, 6'd33, 6'd34}); fails++; end
        tick(); idle(); #1;
        tests++; if (FreelistHead !== 5'd3) begin $display("FAIL rstmid_tail: head=%0d exp=3", FreelistHead); fails++; end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_compaction();
        test_fill_wrap();
        test_recovery();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
